// File: rtl/contador_horizontal_timing.sv
// 640x480 horizontal timing: pixel divider, column counter 0..H_TOTAL-1, region FSM, registered hsync and vflag strobe.
// pixel_tick/vflag are decoded from registered state; Enable=0 freezes everything. Optional macro: PIXEL_TICK_BYPASS_EN.
module contador_horizontal_timing #(
  parameter int CLK_DIV          = 4,
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter bit HSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  output logic [9:0] cntHorizontal,
  output logic       pixel_tick,
  output logic       vflag,
  output logic       hsync,
  output logic       h_active,
  output logic [1:0] h_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] LAST_ACTIVE = 10'(H_ACTIVE - 1);
  localparam logic [9:0] LAST_FRONT  = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] LAST_SYNC   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] LAST_COL    = 10'(H_TOTAL - 1);

  localparam logic HSYNC_ON  = HSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic HSYNC_OFF = ~HSYNC_ON;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } hState_t;

  hState_t state;
  hState_t stateNext;

`ifdef PIXEL_TICK_BYPASS_EN
  // Clk already runs at pixel rate: every enabled cycle is a pixel.
  assign pixel_tick = Enable & ~Reset;
`else
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divCnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      divCnt <= '0;
    end else if (Enable) begin
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + DIV_W'(1);
    end
  end

  assign pixel_tick = Enable & ~Reset & (divCnt == DIV_LAST);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cntHorizontal <= '0;
    end else if (pixel_tick) begin
      cntHorizontal <= (cntHorizontal == LAST_COL) ? '0 : cntHorizontal + 10'd1;
    end
  end

  // High in the same cycle as the wrap so the vertical counter steps on that edge.
  assign vflag = pixel_tick & (cntHorizontal == LAST_COL);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ACTIVE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (pixel_tick) begin
      case (state)
        ACTIVE:  if (cntHorizontal == LAST_ACTIVE) stateNext = FRONT;
        FRONT:   if (cntHorizontal == LAST_FRONT)  stateNext = SYNC;
        SYNC:    if (cntHorizontal == LAST_SYNC)   stateNext = BACK;
        BACK:    if (cntHorizontal == LAST_COL)    stateNext = ACTIVE;
        default: stateNext = ACTIVE;
      endcase
    end
  end

  // Registered from the next state so hsync lines up with h_state and never glitches.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hsync <= HSYNC_OFF;
    end else begin
      hsync <= (stateNext == SYNC) ? HSYNC_ON : HSYNC_OFF;
    end
  end

  assign h_state  = state;
  assign h_active = (state == ACTIVE);

endmodule

// File: tb/tb_contador_horizontal_timing.sv
// Directed bench for contador_horizontal_timing: reset, first tick, full line, enable freeze, mid-line reset, vflag period.
module tb_contador_horizontal_timing;

`ifdef PIXEL_TICK_BYPASS_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 4;
`endif
  localparam int HOLD_PH = (DIV > 1) ? 1 : 0;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b1;
  logic [9:0] cntHorizontal;
  logic       pixel_tick;
  logic       vflag;
  logic       hsync;
  logic       h_active;
  logic [1:0] h_state;

  int compared = 0;
  int mismatched = 0;

  int mCnt = 0;
  int mPh = 0;
  int vertCnt = 0;
  int vflagCnt = 0;
  int hsLowClk = 0;
  int hsLowTicks = 0;
  int colFront = -1;
  int colSync = -1;
  int colBack = -1;
  int guard;
  int period;

  contador_horizontal_timing dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Enable        (Enable),
    .cntHorizontal (cntHorizontal),
    .pixel_tick    (pixel_tick),
    .vflag         (vflag),
    .hsync         (hsync),
    .h_active      (h_active),
    .h_state       (h_state)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int region(input int c);
    if (c < 640) return 0;
    if (c < 656) return 1;
    if (c < 752) return 2;
    return 3;
  endfunction

  task automatic adv();
    @(negedge Clk);
    #2;
  endtask

  // Compare the current cycle against the model, then advance model and clock.
  task automatic step();
    logic expTick;
    expTick = Enable && !Reset && (mPh == DIV - 1);
    chk("cnt", 32'(cntHorizontal), 32'(mCnt));
    chk("tick", 32'(pixel_tick), 32'(expTick));
    chk("vflag", 32'(vflag), 32'(expTick && mCnt == 799));
    chk("state", 32'(h_state), 32'(region(mCnt)));
    chk("hsync", 32'(hsync), 32'(region(mCnt) == 2 ? 0 : 1));
    chk("h_active", 32'(h_active), 32'(region(mCnt) == 0));
    if (vflag === 1'b1) begin
      vflagCnt++;
      vertCnt++;
    end
    if (hsync === 1'b0) begin
      hsLowClk++;
      if (pixel_tick === 1'b1) hsLowTicks++;
    end
    if (h_state === 2'd1 && colFront < 0) colFront = int'(cntHorizontal);
    if (h_state === 2'd2 && colSync < 0)  colSync  = int'(cntHorizontal);
    if (h_state === 2'd3 && colBack < 0)  colBack  = int'(cntHorizontal);
    if (Reset) begin
      mCnt = 0;
      mPh = 0;
    end else if (Enable) begin
      if (expTick) mCnt = (mCnt == 799) ? 0 : mCnt + 1;
      mPh = (mPh == DIV - 1) ? 0 : mPh + 1;
    end
    adv();
  endtask

  initial begin
    // Reset held for three edges
    Reset = 1'b1;
    Enable = 1'b1;
    repeat (3) @(posedge Clk);
    adv();
    chk("rst_cnt", 32'(cntHorizontal), 32'd0);
    chk("rst_state", 32'(h_state), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_hactive", 32'(h_active), 32'd1);
    chk("rst_tick", 32'(pixel_tick), 32'd0);
    chk("rst_vflag", 32'(vflag), 32'd0);

    // Release: first tick in cycle DIV after release
    Reset = 1'b0;
    #1;
    for (int c = 1; c <= DIV; c++) begin
      chk("first_tick", 32'(pixel_tick), 32'(c == DIV));
      step();
    end
    chk("cnt_after_first", 32'(cntHorizontal), 32'd1);

    // One full line
    vflagCnt = 0; vertCnt = 0; hsLowClk = 0; hsLowTicks = 0;
    colFront = -1; colSync = -1; colBack = -1;
    repeat (800 * DIV) step();
    chk("line_vflag_count", 32'(vflagCnt), 32'd1);
    chk("vert_advance", 32'(vertCnt), 32'd1);
    chk("hsync_low_clk", 32'(hsLowClk), 32'(96 * DIV));
    chk("hsync_low_ticks", 32'(hsLowTicks), 32'd96);
    chk("col_front", 32'(colFront), 32'd640);
    chk("col_sync", 32'(colSync), 32'd656);
    chk("col_back", 32'(colBack), 32'd752);
    chk("line_end_cnt", 32'(cntHorizontal), 32'd1);

    // Enable dropped at column 700 mid-divider
    guard = 0;
    while (!(mCnt == 700 && mPh == HOLD_PH) && guard < 5000 * DIV) begin
      step();
      guard++;
    end
    chk("reach_700", 32'(guard < 5000 * DIV), 32'd1);
    Enable = 1'b0;
    #1;
    vflagCnt = 0;
    repeat (10) step();
    chk("frozen_vflags", 32'(vflagCnt), 32'd0);
    chk("frozen_cnt", 32'(cntHorizontal), 32'd700);
    chk("frozen_state", 32'(h_state), 32'd2);
    chk("frozen_hsync", 32'(hsync), 32'd0);
    Enable = 1'b1;
    #1;
    repeat (DIV - HOLD_PH - 1) step();
    chk("resume_pre", 32'(cntHorizontal), 32'd700);
    step();
    chk("resume_701", 32'(cntHorizontal), 32'd701);

    // Reset at column 700 while hsync is asserted
    guard = 0;
    while (!(mCnt == 700) && guard < 5000 * DIV) begin
      step();
      guard++;
    end
    chk("reach_700b", 32'(guard < 5000 * DIV), 32'd1);
    chk("pre_rst_hsync", 32'(hsync), 32'd0);
    Reset = 1'b1;
    #1;
    chk("in_rst_tick", 32'(pixel_tick), 32'd0);
    step();
    chk("midrst_cnt", 32'(cntHorizontal), 32'd0);
    chk("midrst_state", 32'(h_state), 32'd0);
    chk("midrst_hsync", 32'(hsync), 32'd1);
    chk("midrst_vflag", 32'(vflag), 32'd0);
    Reset = 1'b0;
    #1;

    // vflag period equals one line
    guard = 0;
    while (vflag !== 1'b1 && guard < 1000 * DIV) begin
      step();
      guard++;
    end
    chk("vflag_seen", 32'(vflag), 32'd1);
    step();
    period = 1;
    while (vflag !== 1'b1 && period < 1000 * DIV) begin
      step();
      period++;
    end
    chk("vflag_period", 32'(period), 32'(800 * DIV));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
